// File: rtl/panel_sequencer.sv
// LED-cube layer scanner: loads, clocks, latches and displays one layer per pass.
// Define PANEL_SEQ_BRIGHTNESS_EN to add the brightness-reload phase driven by brightness_req.
module panel_sequencer #(
    parameter int WIDTH          = 16,
    parameter int CLK_DIV        = 2,
    parameter int NUM_LAYERS     = 8,
    parameter int LAYER_BITS     = 3,
    parameter int LATCH_CYCLES   = 2,
    parameter int DISPLAY_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  brightness_req,
    output logic                  shift,
    output logic                  load_led_vals,
    output logic                  load_brightness,
    output logic                  serial_clk,
    output logic                  latch,
    output logic                  blank,
    output logic                  bright_mode,
    output logic [LAYER_BITS-1:0] layer,
    output logic                  frame_done,
    output logic                  busy
);

    localparam int DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int DWELL_MAX = (LATCH_CYCLES > DISPLAY_CYCLES) ? LATCH_CYCLES : DISPLAY_CYCLES;
    localparam int DWELL_W   = (DWELL_MAX > 1) ? $clog2(DWELL_MAX) : 1;

    localparam logic [DIV_W-1:0]      DIV_LAST     = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]      BIT_LAST     = BIT_W'(WIDTH - 1);
    localparam logic [DWELL_W-1:0]    LATCH_LAST   = DWELL_W'(LATCH_CYCLES - 1);
    localparam logic [DWELL_W-1:0]    DISPLAY_LAST = DWELL_W'(DISPLAY_CYCLES - 1);
    localparam logic [LAYER_BITS-1:0] LAYER_LAST   = LAYER_BITS'(NUM_LAYERS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_LATCH,
        S_DISPLAY
    } state_e;

    state_e                  state_q, state_d;
    logic [DIV_W-1:0]        div_q, div_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic [DWELL_W-1:0]      dwell_q, dwell_d;
    logic [LAYER_BITS-1:0]   layer_q, layer_d;
    logic                    bright_q, bright_d;
    logic                    bright_avail;
    logic                    wrap;

    logic shift_q, shift_d;
    logic load_led_q, load_led_d;
    logic load_bright_q, load_bright_d;
    logic sclk_q, sclk_d;
    logic latch_q, latch_d;
    logic blank_q, blank_d;
    logic bright_mode_q, bright_mode_d;
    logic frame_done_q, frame_done_d;
    logic busy_q, busy_d;

`ifdef PANEL_SEQ_BRIGHTNESS_EN
    logic pending_q, pending_d;
    logic take_bright;

    // A brightness phase begins exactly when bright rises; a request in that same cycle survives.
    assign take_bright  = bright_d & ~bright_q;
    assign bright_avail = pending_q;

    always_comb begin
        pending_d = pending_q;
        if (take_bright)    pending_d = 1'b0;
        if (brightness_req) pending_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pending_q <= 1'b0;
        else          pending_q <= pending_d;
    end
`else
    logic unused_brightness_req;
    assign unused_brightness_req = brightness_req;
    assign bright_avail          = 1'b0;
`endif

    // State register, counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            div_q         <= '0;
            bit_q         <= '0;
            dwell_q       <= '0;
            layer_q       <= '0;
            bright_q      <= 1'b0;
            shift_q       <= 1'b0;
            load_led_q    <= 1'b0;
            load_bright_q <= 1'b0;
            sclk_q        <= 1'b0;
            latch_q       <= 1'b0;
            blank_q       <= 1'b1;
            bright_mode_q <= 1'b0;
            frame_done_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q       <= state_d;
            div_q         <= div_d;
            bit_q         <= bit_d;
            dwell_q       <= dwell_d;
            layer_q       <= layer_d;
            bright_q      <= bright_d;
            shift_q       <= shift_d;
            load_led_q    <= load_led_d;
            load_bright_q <= load_bright_d;
            sclk_q        <= sclk_d;
            latch_q       <= latch_d;
            blank_q       <= blank_d;
            bright_mode_q <= bright_mode_d;
            frame_done_q  <= frame_done_d;
            busy_q        <= busy_d;
        end
    end

    always_comb begin
        // NOTE: hold-by-default assignments keep this block free of inferred latches.
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        dwell_d  = dwell_q;
        layer_d  = layer_q;
        bright_d = bright_q;
        wrap     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d  = S_LOAD;
                    bright_d = bright_avail;
                end
            end
            S_LOAD: begin
                state_d = S_SHIFT_LO;
                div_d   = '0;
                bit_d   = '0;
            end
            S_SHIFT_LO: begin
                if (div_q == DIV_LAST) begin
                    state_d = S_SHIFT_HI;
                    div_d   = '0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_SHIFT_HI: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = S_LATCH;
                        dwell_d = '0;
                    end else begin
                        state_d = S_SHIFT_LO;
                        bit_d   = bit_q + 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_LATCH: begin
                if (dwell_q == LATCH_LAST) begin
                    dwell_d = '0;
                    if (bright_q) begin
                        // Brightness data latched: reload LED values for the same layer.
                        state_d  = S_LOAD;
                        bright_d = 1'b0;
                    end else begin
                        state_d = S_DISPLAY;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            S_DISPLAY: begin
                if (dwell_q == DISPLAY_LAST) begin
                    dwell_d = '0;
                    wrap    = (layer_q == LAYER_LAST);
                    layer_d = (layer_q == LAYER_LAST) ? '0 : layer_q + 1'b1;
                    if (enable) begin
                        state_d  = S_LOAD;
                        bright_d = bright_avail;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with state_q.
    always_comb begin
        shift_d       = (state_d == S_SHIFT_HI) && (div_d == DIV_LAST);
        load_led_d    = (state_d == S_LOAD) && !bright_d;
        load_bright_d = (state_d == S_LOAD) && bright_d;
        sclk_d        = (state_d == S_SHIFT_HI);
        latch_d       = (state_d == S_LATCH);
        blank_d       = (state_d != S_DISPLAY);
        bright_mode_d = bright_d && (state_d != S_IDLE) && (state_d != S_DISPLAY);
        frame_done_d  = wrap;
        busy_d        = (state_d != S_IDLE);
    end

    assign shift           = shift_q;
    assign load_led_vals   = load_led_q;
    assign load_brightness = load_bright_q;
    assign serial_clk      = sclk_q;
    assign latch           = latch_q;
    assign blank           = blank_q;
    assign bright_mode     = bright_mode_q;
    assign layer           = layer_q;
    assign frame_done      = frame_done_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_panel_sequencer.sv
// Bench for panel_sequencer: directed scan scenarios plus randomized enable/brightness/reset traffic,
// each cycle checked against an offset-based timing model of one layer pass.
module tb_panel_sequencer;

    localparam int WIDTH          = 16;
    localparam int CLK_DIV        = 2;
    localparam int NUM_LAYERS     = 2;
    localparam int LAYER_BITS     = 1;
    localparam int LATCH_CYCLES   = 2;
    localparam int DISPLAY_CYCLES = 8;

`ifdef PANEL_SEQ_BRIGHTNESS_EN
    localparam bit BR_EN = 1'b1;
`else
    localparam bit BR_EN = 1'b0;
`endif

    // Offsets within one pass, counted from its LOAD cycle.
    localparam int LATCH_START = 1 + 2 * CLK_DIV * WIDTH;
    localparam int DISP_START  = LATCH_START + LATCH_CYCLES;
    localparam int LED_LEN     = DISP_START + DISPLAY_CYCLES;
    localparam int BRIGHT_LEN  = DISP_START;

    // {shift, load_led, load_bright, sclk, latch, blank, bright_mode, layer, frame_done, busy}
    localparam logic [9:0] RESET_VEC = 10'b00000_1_0_0_0_0;

    logic                  clk;
    logic                  reset_n;
    logic                  enable;
    logic                  brightness_req;
    logic                  shift;
    logic                  load_led_vals;
    logic                  load_brightness;
    logic                  serial_clk;
    logic                  latch;
    logic                  blank;
    logic                  bright_mode;
    logic [LAYER_BITS-1:0] layer;
    logic                  frame_done;
    logic                  busy;

    panel_sequencer #(
        .WIDTH         (WIDTH),
        .CLK_DIV       (CLK_DIV),
        .NUM_LAYERS    (NUM_LAYERS),
        .LAYER_BITS    (LAYER_BITS),
        .LATCH_CYCLES  (LATCH_CYCLES),
        .DISPLAY_CYCLES(DISPLAY_CYCLES)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .brightness_req (brightness_req),
        .shift          (shift),
        .load_led_vals  (load_led_vals),
        .load_brightness(load_brightness),
        .serial_clk     (serial_clk),
        .latch          (latch),
        .blank          (blank),
        .bright_mode    (bright_mode),
        .layer          (layer),
        .frame_done     (frame_done),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [9:0] dut_vec;
    assign dut_vec = {shift, load_led_vals, load_brightness, serial_clk, latch,
                      blank, bright_mode, layer, frame_done, busy};

    int vectors;
    int miscompares;

    // Reference model: where we are inside the current pass, not how the FSM gets there.
    bit m_busy;
    int m_off;
    bit m_bright;
    int m_layer;
    bit m_pending;
    bit m_frame;

    logic [9:0] last_obs;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_busy    = 1'b0;
        m_off     = 0;
        m_bright  = 1'b0;
        m_layer   = 0;
        m_pending = 1'b0;
        m_frame   = 1'b0;
    endfunction

    function automatic logic [9:0] model_vec();
        logic sh, ll, lb, sc, la, bl, bm;
        int   k;
        sh = 1'b0; ll = 1'b0; lb = 1'b0; sc = 1'b0; la = 1'b0; bl = 1'b1; bm = 1'b0;
        if (m_busy) begin
            bm = m_bright;
            if (m_off == 0) begin
                ll = !m_bright;
                lb = m_bright;
            end else if (m_off < LATCH_START) begin
                k  = (m_off - 1) % (2 * CLK_DIV);
                sc = (k >= CLK_DIV);
                sh = (k == 2 * CLK_DIV - 1);
            end else if (m_off < DISP_START) begin
                la = 1'b1;
            end else begin
                bl = 1'b0;
            end
        end
        return {sh, ll, lb, sc, la, bl, bm, 1'(m_layer), m_frame, m_busy};
    endfunction

    function automatic void model_edge(input logic en, input logic req);
        bit take;
        take    = 1'b0;
        m_frame = 1'b0;
        if (!m_busy) begin
            if (en) begin
                m_busy   = 1'b1;
                m_off    = 0;
                m_bright = m_pending;
                take     = m_pending;
            end
        end else begin
            m_off++;
            if (m_bright && m_off == BRIGHT_LEN) begin
                m_bright = 1'b0;
                m_off    = 0;
            end else if (!m_bright && m_off == LED_LEN) begin
                m_layer = (m_layer + 1) % NUM_LAYERS;
                m_frame = (m_layer == 0);
                if (en) begin
                    m_off    = 0;
                    m_bright = m_pending;
                    take     = m_pending;
                end else begin
                    m_busy = 1'b0;
                end
            end
        end
        if (take) m_pending = 1'b0;
        if (req && BR_EN) m_pending = 1'b1;
    endfunction

    // One clock: drive inputs, compare at the falling edge, advance the model at the rising edge.
    task automatic step(input logic en, input logic req, input string tag);
        // NOTE: inputs change 1 time unit after the rising edge, so blocking writes cannot race the DUT.
        enable         = en;
        brightness_req = req;
        @(negedge clk);
        last_obs = dut_vec;
        check(tag, {22'b0, dut_vec}, {22'b0, model_vec()});
        @(posedge clk);
        model_edge(en, req);
        #1;
    endtask

    task automatic async_reset(input string tag);
        #2;
        reset_n = 1'b0;
        #1;
        check(tag, {22'b0, dut_vec}, {22'b0, RESET_VEC});
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    int  first_load, second_load, first_shift, first_latch, first_unblank;
    int  nshift, frame_cnt, frame_at;
    int  n_lb, n_bm, lb_layer, led_layer;
    logic en_r;

    initial begin
        vectors        = 0;
        miscompares    = 0;
        reset_n        = 1'b0;
        enable         = 1'b0;
        brightness_req = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {22'b0, dut_vec}, {22'b0, RESET_VEC});
        reset_n = 1'b1;
        step(1'b0, 1'b0, "idle");
        step(1'b0, 1'b0, "idle");

        // Continuous scan of two layers plus the start of the next frame.
        first_load = -1; second_load = -1; first_shift = -1; first_latch = -1;
        first_unblank = -1; nshift = 0; frame_cnt = 0; frame_at = -1;
        for (int c = 0; c < 160; c++) begin
            step(1'b1, 1'b0, "scan");
            if (last_obs[8]) begin
                if (first_load < 0) first_load = c;
                else if (second_load < 0) second_load = c;
            end
            if (last_obs[9]) begin
                if (first_shift < 0) first_shift = c;
                if (first_latch < 0) nshift++;
            end
            if (last_obs[5] && first_latch < 0) first_latch = c;
            if (!last_obs[4] && first_unblank < 0) first_unblank = c;
            if (last_obs[1]) begin
                frame_cnt++;
                frame_at = c;
            end
        end
        check("first_load_cycle", first_load, 1);
        check("first_shift_cycle", first_shift, 5);
        check("shifts_before_latch", nshift, WIDTH);
        check("first_latch_cycle", first_latch, 66);
        check("first_unblank_cycle", first_unblank, 68);
        check("layer_period", second_load - first_load, 75);
        check("frame_done_count", frame_cnt, 1);
        check("frame_done_cycle", frame_at, 151);

        // Enable dropped mid-shift: the layer still completes, then the scan parks.
        for (int i = 0; i < 200; i++) begin
            step(1'b0, 1'b0, "drain");
            if (!last_obs[0]) break;
        end
        check("parked_busy", last_obs[0], 0);
        check("parked_layer", last_obs[2], 1);

        // Brightness request while idle, then enable.
        step(1'b0, 1'b1, "breq");
        n_lb = 0; n_bm = 0; first_load = -1; first_unblank = -1; lb_layer = -1; led_layer = -1;
        for (int c = 0; c < 150; c++) begin
            step(1'b1, 1'b0, "bright");
            if (last_obs[7]) begin
                n_lb++;
                lb_layer = int'(last_obs[2]);
            end
            if (last_obs[8] && first_load < 0) begin
                first_load = c;
                led_layer  = int'(last_obs[2]);
            end
            if (last_obs[3]) n_bm++;
            if (!last_obs[4] && first_unblank < 0) first_unblank = c;
        end
        check("bright_load_count", n_lb, BR_EN ? 1 : 0);
        check("bright_mode_cycles", n_bm, BR_EN ? BRIGHT_LEN : 0);
        check("led_load_after_bright", first_load, BR_EN ? 68 : 1);
        check("unblank_after_bright", first_unblank, BR_EN ? 135 : 68);
        check("bright_same_layer", led_layer, BR_EN ? lb_layer : 1);
        for (int i = 0; i < 200; i++) begin
            step(1'b0, 1'b0, "drain2");
            if (!last_obs[0]) break;
        end
        check("parked_busy2", last_obs[0], 0);

        // Reset while serial_clk is high abandons the layer.
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 1'b0, "pre_reset");
            if (m_busy && m_off == 1 + CLK_DIV) break;
        end
        check("in_shift_hi", serial_clk, 1);
        async_reset("reset_mid_shift");
        step(1'b1, 1'b0, "post_reset");
        step(1'b1, 1'b0, "post_reset");
        check("post_reset_load", {last_obs[8], last_obs[7], last_obs[2]}, 3'b100);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, "post_reset");

        // Randomized traffic with occasional brightness pulses and asynchronous resets.
        en_r = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) en_r = ~en_r;
            step(en_r, 1'($urandom_range(0, 24) == 0), "random");
            if ($urandom_range(0, 599) == 0) async_reset("random_reset");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
